// File: rtl/ctrl_pipe.sv
// ctrl_pipe: per-stage stall/flush carrier for decoded control words with kill masking
module ctrl_pipe #(
    parameter int unsigned      WIDTH      = 16,
    parameter int unsigned      STAGES     = 3,
    parameter int unsigned      KILL_STAGE = 1,
    parameter logic [WIDTH-1:0] WE_MASK    = 16'h0800
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_ctrl,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    input  logic                      kill,
    output logic                      in_ready,
    output logic [STAGES-1:0]         out_valid,
    output logic [STAGES*WIDTH-1:0]   out_ctrl
);
    logic [STAGES-1:0]             r_valid;
    logic [STAGES-1:0][WIDTH-1:0]  r_ctrl;
    logic [STAGES-1:0]             w_eff_stall;
    logic                          w_acc;
    // A held stage also holds every older stage: OR-reduce stall from the tail down
    always_comb begin
        w_acc       = 1'b0;
        w_eff_stall = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_acc          = w_acc | stall[i];
            w_eff_stall[i] = w_acc;
        end
    end
    assign in_ready  = ~w_eff_stall[0];
    assign out_valid = r_valid;
    assign out_ctrl  = r_ctrl;
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_ctrl;
        logic             w_up_stall;
        logic [WIDTH-1:0] w_load;
        if (g == 0) begin : g_head
            assign w_src_valid = in_valid;
            assign w_src_ctrl  = in_ctrl;
            assign w_up_stall  = 1'b0;
        end else begin : g_body
            assign w_src_valid = r_valid[g-1];
            assign w_src_ctrl  = r_ctrl[g-1];
            assign w_up_stall  = w_eff_stall[g-1];
        end
        // Invalid words are stored as zero; kill clears write enables at the kill boundary only
        assign w_load = w_src_ctrl & {WIDTH{w_src_valid}}
                      & ~((g == KILL_STAGE && kill) ? WE_MASK : '0);
        // Stage register: reset/flush clear, stall holds, held upstream inserts a bubble, else load
        always_ff @(posedge clk) begin
            if (rst || flush[g]) begin
                r_valid[g] <= 1'b0;
                r_ctrl[g]  <= '0;
            end else if (w_eff_stall[g]) begin
                r_valid[g] <= r_valid[g];
                r_ctrl[g]  <= r_ctrl[g];
            end else if (w_up_stall) begin
                r_valid[g] <= 1'b0;
                r_ctrl[g]  <= '0;
            end else begin
                r_valid[g] <= w_src_valid;
                r_ctrl[g]  <= w_load;
            end
        end
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed vector table plus randomized comparison against a reference model
module tb_ctrl_pipe;
    localparam int W = 16;
    localparam int S = 3;
    localparam int KS = 1;
    localparam logic [W-1:0] WM = 16'h0800;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_ctrl = '0;
    logic [S-1:0]     stall = '0;
    logic [S-1:0]     flush = '0;
    logic             kill = 1'b0;
    logic             in_ready;
    logic [S-1:0]     out_valid;
    logic [S*W-1:0]   out_ctrl;

    int checks = 0;
    int errors = 0;

    ctrl_pipe #(.WIDTH(W), .STAGES(S), .KILL_STAGE(KS), .WE_MASK(WM)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .stall(stall), .flush(flush), .kill(kill), .in_ready(in_ready),
        .out_valid(out_valid), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         iv;
        logic [W-1:0] ic;
        logic [S-1:0] st;
        logic [S-1:0] fl;
        logic         kl;
        logic         rdy;
        logic [S-1:0] v;
        logic [W-1:0] c0;
        logic [W-1:0] c1;
        logic [W-1:0] c2;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    // reference model state
    logic         mv[S];
    logic [W-1:0] mc[S];

    task automatic model_step();
        logic         nv[S];
        logic [W-1:0] nc[S];
        logic         held[S];
        logic         sv;
        logic [W-1:0] sc;
        for (int i = 0; i < S; i++) begin
            held[i] = 1'b0;
            for (int k = i; k < S; k++) if (stall[k]) held[i] = 1'b1;
        end
        for (int i = 0; i < S; i++) begin
            sv = (i == 0) ? in_valid : mv[i-1];
            sc = (i == 0) ? in_ctrl : mc[i-1];
            if (!sv) sc = '0;
            if (i == KS && kill) sc = sc & ~WM;
            if (rst || flush[i]) begin nv[i] = 0; nc[i] = '0; end
            else if (held[i]) begin nv[i] = mv[i]; nc[i] = mc[i]; end
            else if (i > 0 && held[i-1]) begin nv[i] = 0; nc[i] = '0; end
            else begin nv[i] = sv; nc[i] = sc; end
        end
        for (int i = 0; i < S; i++) begin mv[i] = nv[i]; mc[i] = nc[i]; end
    endtask

    initial begin
        //           rst iv ic        st      fl      kl  rdy v       c0       c1       c2
        tbl[0]  = '{1, 0, 16'h0000, 3'b000, 3'b000, 0, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000};
        tbl[1]  = '{0, 1, 16'h1234, 3'b000, 3'b000, 0, 1, 3'b001, 16'h1234, 16'h0000, 16'h0000};
        tbl[2]  = '{0, 1, 16'h5678, 3'b000, 3'b000, 0, 1, 3'b011, 16'h5678, 16'h1234, 16'h0000};
        tbl[3]  = '{0, 1, 16'h9ABC, 3'b000, 3'b000, 0, 1, 3'b111, 16'h9ABC, 16'h5678, 16'h1234};
        tbl[4]  = '{0, 1, 16'h1111, 3'b010, 3'b000, 0, 0, 3'b011, 16'h9ABC, 16'h5678, 16'h0000};
        tbl[5]  = '{0, 1, 16'h0FFF, 3'b000, 3'b000, 0, 1, 3'b111, 16'h0FFF, 16'h9ABC, 16'h5678};
        tbl[6]  = '{0, 0, 16'hBEEF, 3'b000, 3'b000, 1, 1, 3'b110, 16'h0000, 16'h07FF, 16'h9ABC};
        tbl[7]  = '{0, 1, 16'h0FFF, 3'b000, 3'b000, 0, 1, 3'b101, 16'h0FFF, 16'h0000, 16'h07FF};
        tbl[8]  = '{0, 1, 16'h2222, 3'b010, 3'b000, 1, 0, 3'b001, 16'h0FFF, 16'h0000, 16'h0000};
        tbl[9]  = '{0, 1, 16'hFFFF, 3'b000, 3'b000, 0, 1, 3'b011, 16'hFFFF, 16'h0FFF, 16'h0000};
        tbl[10] = '{0, 1, 16'hAAAA, 3'b000, 3'b000, 0, 1, 3'b111, 16'hAAAA, 16'hFFFF, 16'h0FFF};
        tbl[11] = '{0, 1, 16'h5555, 3'b010, 3'b010, 0, 0, 3'b001, 16'hAAAA, 16'h0000, 16'h0000};
        tbl[12] = '{0, 1, 16'h1111, 3'b000, 3'b000, 0, 1, 3'b011, 16'h1111, 16'hAAAA, 16'h0000};
        tbl[13] = '{0, 1, 16'h2222, 3'b000, 3'b000, 0, 1, 3'b111, 16'h2222, 16'h1111, 16'hAAAA};
        tbl[14] = '{0, 1, 16'h3333, 3'b100, 3'b000, 0, 0, 3'b111, 16'h2222, 16'h1111, 16'hAAAA};
        tbl[15] = '{1, 1, 16'h4444, 3'b000, 3'b000, 0, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000};
        tbl[16] = '{0, 1, 16'h4444, 3'b000, 3'b000, 0, 1, 3'b001, 16'h4444, 16'h0000, 16'h0000};
        tbl[17] = '{0, 1, 16'h6666, 3'b000, 3'b001, 0, 1, 3'b010, 16'h0000, 16'h4444, 16'h0000};
        tbl[18] = '{0, 0, 16'h7777, 3'b000, 3'b010, 1, 1, 3'b100, 16'h0000, 16'h0000, 16'h4444};

        @(posedge clk); #1;
        for (int n = 0; n < 19; n++) begin
            rst = tbl[n].rst; in_valid = tbl[n].iv; in_ctrl = tbl[n].ic;
            stall = tbl[n].st; flush = tbl[n].fl; kill = tbl[n].kl;
            #1;
            chk("vec_ready", n, 32'(in_ready), 32'(tbl[n].rdy));
            @(posedge clk); #1;
            chk("vec_valid", n, 32'(out_valid), 32'(tbl[n].v));
            chk("vec_c0", n, 32'(out_ctrl[0*W +: W]), 32'(tbl[n].c0));
            chk("vec_c1", n, 32'(out_ctrl[1*W +: W]), 32'(tbl[n].c1));
            chk("vec_c2", n, 32'(out_ctrl[2*W +: W]), 32'(tbl[n].c2));
        end

        // randomized run, starting from a reset so model and DUT agree
        for (int i = 0; i < S; i++) begin mv[i] = 0; mc[i] = '0; end
        for (int n = 0; n < 2000; n++) begin
            logic exp_rdy;
            rst      = (n == 0) || ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_ctrl  = W'($urandom);
            for (int i = 0; i < S; i++) begin
                stall[i] = ($urandom_range(0, 4) == 0);
                flush[i] = ($urandom_range(0, 9) == 0);
            end
            kill = ($urandom_range(0, 2) == 0);
            #1;
            exp_rdy = 1'b1;
            for (int i = 0; i < S; i++) if (stall[i]) exp_rdy = 1'b0;
            chk("rnd_ready", n, 32'(in_ready), 32'(exp_rdy));
            model_step();
            @(posedge clk); #1;
            for (int i = 0; i < S; i++) begin
                chk("rnd_valid", n * S + i, 32'(out_valid[i]), 32'(mv[i]));
                chk("rnd_ctrl", n * S + i, 32'(out_ctrl[i*W +: W]), 32'(mc[i]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
